// File: rtl/alu_pkg.sv
// Shared ALU constants: op_code values, result-mux select codes, encoder state type.
// The ALU result mux uses the same SEL_* constants.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLT = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;

  localparam logic [2:0] SEL_AND = 3'b000;
  localparam logic [2:0] SEL_OR  = 3'b001;
  localparam logic [2:0] SEL_ADD = 3'b010;
  localparam logic [2:0] SEL_SLT = 3'b011;
  localparam logic [2:0] SEL_XOR = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_encoder_if.sv
// Op request / result handshake bundle between decode, the encoder and the result consumer.
interface alu_op_encoder_if #(
  parameter int unsigned CNT_W = 16
);
  logic             op_valid;
  logic [3:0]       op_code;
  logic             op_ready;
  logic [2:0]       alu_sel;
  logic             done_valid;
  logic             done_ready;
  logic             illegal_op;
  logic             busy;
  logic [CNT_W-1:0] ops_retired;

  modport master (
    output op_valid, op_code, done_ready,
    input  op_ready, alu_sel, done_valid, illegal_op, busy, ops_retired
  );

  modport slave (
    input  op_valid, op_code, done_ready,
    output op_ready, alu_sel, done_valid, illegal_op, busy, ops_retired
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational op_code decode: legality, result-mux select and latency class.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [3:0] op_code,
  output logic       legal,
  output logic [2:0] sel,
  output logic       is_arith
);

  always_comb begin
    legal    = 1'b0;
    sel      = SEL_AND;
    is_arith = 1'b0;
    case (op_code)
      OP_AND: begin legal = 1'b1; sel = SEL_AND; end
      OP_OR:  begin legal = 1'b1; sel = SEL_OR;  end
      OP_ADD: begin legal = 1'b1; sel = SEL_ADD; is_arith = 1'b1; end
      OP_SLT: begin legal = 1'b1; sel = SEL_SLT; is_arith = 1'b1; end
      OP_XOR: begin legal = 1'b1; sel = SEL_XOR; end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_op_encoder.sv
// ALU op encoder: registers the result-mux select, holds it for the class settle time,
// then offers the settled result on a valid/ready handshake and counts retired ops.
module alu_op_encoder
  import alu_pkg::*;
#(
  parameter int unsigned LAT_LOGIC = 1,
  parameter int unsigned LAT_ARITH = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic           clk,
  input  logic           reset,
  alu_op_encoder_if.slave bus
);

  localparam int unsigned LAT_MAX = (LAT_LOGIC > LAT_ARITH) ? LAT_LOGIC : LAT_ARITH;
  localparam int unsigned LW      = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam logic [LW-1:0] LOAD_LOGIC = LW'(LAT_LOGIC - 1);
  localparam logic [LW-1:0] LOAD_ARITH = LW'(LAT_ARITH - 1);

  state_t           state, state_nx;
  logic [LW-1:0]    cnt;
  logic [2:0]       sel_q;
  logic             illegal_q;
  logic [CNT_W-1:0] retired;

  logic             dec_legal;
  logic [2:0]       dec_sel;
  logic             dec_arith;
  logic             ready;
  logic             accept;

  alu_op_decode u_decode (
    .op_code  (bus.op_code),
    .legal    (dec_legal),
    .sel      (dec_sel),
    .is_arith (dec_arith)
  );

  assign accept = bus.op_valid & ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept && dec_legal) state_nx = ST_EXEC;
      ST_EXEC: if (cnt == '0)           state_nx = ST_DONE;
      ST_DONE: if (bus.done_ready)      state_nx = ST_IDLE;
      default:                          state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    ready          = 1'b0;
    bus.done_valid = 1'b0;
    bus.busy       = 1'b1;
    case (state)
      ST_IDLE: begin ready = 1'b1; bus.busy = 1'b0; end
      ST_DONE: bus.done_valid = 1'b1;
      default: ;
    endcase
  end

  // Select only moves on a legal accept; illegal codes leave the mux untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q     <= SEL_AND;
      cnt       <= '0;
      illegal_q <= 1'b0;
      retired   <= '0;
    end else begin
      illegal_q <= accept & ~dec_legal;
      case (state)
        ST_IDLE: begin
          if (accept && dec_legal) begin
            sel_q <= dec_sel;
            cnt   <= dec_arith ? LOAD_ARITH : LOAD_LOGIC;
          end
        end
        ST_EXEC: if (cnt != '0) cnt <= cnt - LW'(1);
        ST_DONE: if (bus.done_ready) retired <= retired + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.op_ready    = ready;
  assign bus.alu_sel     = sel_q;
  assign bus.illegal_op  = illegal_q;
  assign bus.ops_retired = retired;

endmodule
